load_store_unit: RTL

// - Execute-stage consumer of the ALU result. Treats ALUout as the effective address for LB/LH/LW/LBU/LHU/SB/SH/SW.
// - Drives a req/gnt/rvalid data-memory port and generates byte enables and store-lane replication.
// - Returns sign- or zero-extended load data to writeback.
// - Multi-cycle: the core holds the instruction while req_ready=0.

---
 rtl/load_store_unit_if.sv | 42 ++++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle: core request/response side plus the data-memory
// req/gnt/rvalid port. The LSU uses the slave view; the core/memory side (or a
// bench) uses the master view.
interface load_store_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    // Core side
    logic                  req_valid;
    logic                  req_ready;
    logic                  is_store;
    logic [1:0]            size;
    logic                  unsigned_ld;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  misalign;
    // Memory side
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, is_store, size, unsigned_ld, addr, wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, rdata, misalign,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, is_store, size, unsigned_ld, addr, wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, rdata, misalign,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: takes the ALU result as effective address, drives a
// req/gnt/rvalid data-memory port with byte enables and lane-replicated store
// data, and returns sign/zero-extended load data.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned accesses skip the
// memory and complete immediately with misalign=1. Without it, misalign is 0
// and low offset bits are ignored for half/word accesses.
// Only DATA_WIDTH = 32 (4 byte lanes) is supported.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.slave  bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    logic [1:0]            state, state_next;
    logic                  is_store_q, unsigned_q;
    logic [1:0]            size_q, off_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;

    logic [1:0]            req_off;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  accept;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] shifted, ld_data;

    assign req_off = bus.addr[1:0];
    assign accept  = (state == StIdle) && bus.req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    logic req_mis, misalign_q;
    // Misalignment of the incoming request, decided at accept time
    always_comb begin
        req_mis = 1'b0;
        case (bus.size)
            2'b00:   req_mis = 1'b0;
            2'b01:   req_mis = req_off[0];
            default: req_mis = (req_off != 2'b00);
        endcase
    end
`endif

    // Byte enables and store-lane replication for the incoming request
    always_comb begin
        req_be    = 4'hF;
        req_wdata = bus.wdata;
        case (bus.size)
            2'b00: begin
                req_be    = 4'b0001 << req_off;
                req_wdata = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                // addr[0] ignored: halves sit on lanes 0-1 or 2-3
                req_be    = req_off[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{bus.wdata[15:0]}};
            end
            default: begin
                req_be    = 4'hF;
                req_wdata = bus.wdata;
            end
        endcase
    end

    // FSM next-state
    always_comb begin
        state_next = state;
        case (state)
            StIdle: begin
                if (bus.req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_next = req_mis ? StResp : StReq;
`else
                    state_next = StReq;
`endif
                end
            end
            StReq:   if (bus.mem_gnt) state_next = is_store_q ? StResp : StWait;
            StWait:  if (bus.mem_rvalid) state_next = StResp;
            default: state_next = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= StIdle;
        else        state <= state_next;
    end

    // Request capture on accept; memory-side outputs hold until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            mem_addr_q <= '0;
            be_q       <= 4'h0;
            wdata_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else if (accept) begin
            is_store_q <= bus.is_store;
            unsigned_q <= bus.unsigned_ld;
            size_q     <= bus.size;
            off_q      <= req_off;
            mem_addr_q <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
            be_q       <= req_be;
            wdata_q    <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= req_mis;
`endif
        end
    end

    // Load extraction: shift the addressed lane down, then extend by size
    always_comb begin
        case (size_q)
            2'b00:   shamt = {off_q, 3'b000};
            2'b01:   shamt = {off_q[1], 4'b0000};
            default: shamt = 5'd0;
        endcase
        shifted = bus.mem_rdata >> shamt;
        case (size_q)
            2'b00:   ld_data = unsigned_q ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ld_data = unsigned_q ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    // Load data register, updated only when memory returns data in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                rdata_q <= '0;
        else if (state == StWait && bus.mem_rvalid) rdata_q <= ld_data;
    end

    assign bus.req_ready  = (state == StIdle);
    assign bus.resp_valid = (state == StResp);
    assign bus.rdata      = rdata_q;
    assign bus.mem_req    = (state == StReq);
    assign bus.mem_we     = (state == StReq) && is_store_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = be_q;
    assign bus.mem_wdata  = wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.misalign   = (state == StResp) && misalign_q;
`else
    assign bus.misalign   = 1'b0;
`endif

endmodule
